chi_rx_link_chan: RTL and testbench

- Parametrised CHI link-layer receive channel for the HN-F, generalising the fixed-size RXRSP receiver.
- Owns a real L-credit counter, a link activation/deactivation FSM and LCrdReturn absorption.
- Filters mis-targeted flits and buffers accepted flits in a FIFO toward the HN-F pipeline.
- Instantiated once per RX channel (REQ/RSP/DAT) with that channel's flit width and field offsets.

---
 rtl/chi_link_pkg.sv | 48 ++++
 rtl/chi_rx_link_chan_if.sv | 21 ++
 rtl/sfifo.sv | 37 +++
 rtl/chi_rx_link_chan.sv | 105 ++++++++++
 tb/tb_chi_rx_link_chan.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chi_link_pkg.sv
// Shared CHI link-layer types and per-channel constants used by the HN-F RX channels.
package chi_link_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      DEACT = 2'd2
   } link_state_e;

   // Width of the L-credit counter exposed on crd_out
   localparam int unsigned CRD_W = 4;

   // LCrdReturn opcodes per channel
   localparam int unsigned REQ_LCRD_RET_OPC = 0;
   localparam int unsigned RSP_LCRD_RET_OPC = 0;
   localparam int unsigned DAT_LCRD_RET_OPC = 0;

   // REQ channel flit layout
   localparam int unsigned REQ_FLIT_W  = 117;
   localparam int unsigned REQ_OPC_LSB = 0;
   localparam int unsigned REQ_OPC_W   = 6;
   localparam int unsigned REQ_TGT_LSB = 110;
   localparam int unsigned REQ_TGT_W   = 7;

   // RSP channel flit layout
   localparam int unsigned RSP_FLIT_W  = 65;
   localparam int unsigned RSP_OPC_LSB = 0;
   localparam int unsigned RSP_OPC_W   = 6;
   localparam int unsigned RSP_TGT_LSB = 58;
   localparam int unsigned RSP_TGT_W   = 7;

   // DAT channel flit layout
   localparam int unsigned DAT_FLIT_W  = 373;
   localparam int unsigned DAT_OPC_LSB = 0;
   localparam int unsigned DAT_OPC_W   = 4;
   localparam int unsigned DAT_TGT_LSB = 366;
   localparam int unsigned DAT_TGT_W   = 7;

   // HN-F node IDs
   localparam int unsigned HNF0_ID = 0;
   localparam int unsigned HNF1_ID = 1;

   // Bits needed to count 0..n inclusive
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/chi_rx_link_chan_if.sv
// CHI RX link-layer signal bundle between a transmitter (master) and receiver (slave).
interface chi_rx_link_chan_if #(
   parameter int unsigned FLIT_W = 65
);
   logic              RXLINKACTIVEREQ;
   logic              RXLINKACTIVEACK;
   logic              RXFLITPEND;
   logic              RXFLITV;
   logic [FLIT_W-1:0] RXFLIT;
   logic              RXLCRDV;

   modport master (
      output RXLINKACTIVEREQ, RXFLITPEND, RXFLITV, RXFLIT,
      input  RXLINKACTIVEACK, RXLCRDV
   );

   modport slave (
      input  RXLINKACTIVEREQ, RXFLITPEND, RXFLITV, RXFLIT,
      output RXLINKACTIVEACK, RXLCRDV
   );
endinterface

// File: rtl/sfifo.sv
// Simple synchronous FIFO storage; the owner tracks occupancy and never overfills it.
module sfifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Pointers wrap explicitly so non-power-of-two depths work
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/chi_rx_link_chan.sv
// CHI link-layer RX channel: link FSM, L-credit issue, LCrdReturn absorption,
// TgtID filtering and a posted queue toward the HN-F pipeline.
module chi_rx_link_chan
   import chi_link_pkg::*;
#(
   parameter int unsigned FLIT_W       = 65,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned NUM_CRD      = 4,
   parameter int unsigned OPC_LSB      = 0,
   parameter int unsigned OPC_W        = 6,
   parameter int unsigned TGT_LSB      = 58,
   parameter int unsigned TGT_W        = 7,
   parameter int unsigned LCRD_RET_OPC = 0,
   parameter int unsigned MY_ID        = 0
) (
   input  logic              clock,
   input  logic              reset,
   chi_rx_link_chan_if.slave link,
   output logic [FLIT_W-1:0] deq_flit,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [CRD_W-1:0]  crd_out,
   output logic              tgt_err,
   output logic              ovf_err
);
   localparam int unsigned OCC_W = cnt_w(DEPTH);

   link_state_e        state_q;
   link_state_e        state_d;
   logic [OCC_W-1:0]   occ_q;
   logic [OCC_W-1:0]   occ_d;
   logic [CRD_W-1:0]   crd_d;
   logic               consume_c;
   logic               ovf_c;
   logic               is_ret_c;
   logic               tgt_ok_c;
   logic               push_c;
   logic               tgt_bad_c;
   logic               pop_c;
   logic               grant_c;
   logic               unused_c;

   // RXFLITPEND is advisory only; fields outside Opcode/TgtID travel untouched
   assign unused_c = ^{link.RXFLITPEND, link.RXFLIT};

   // Credit accounting, flit disposition and link state transitions
   always_comb begin
      state_d   = state_q;
      consume_c = link.RXFLITV && (crd_out != '0);
      ovf_c     = link.RXFLITV && (crd_out == '0);
      is_ret_c  = link.RXFLIT[OPC_LSB +: OPC_W] == OPC_W'(LCRD_RET_OPC);
      tgt_ok_c  = link.RXFLIT[TGT_LSB +: TGT_W] == TGT_W'(MY_ID);
      push_c    = consume_c && !is_ret_c && tgt_ok_c;
      tgt_bad_c = consume_c && !is_ret_c && !tgt_ok_c;
      pop_c     = deq_ready && deq_valid;
      occ_d     = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
      // Grant only if the new credit still has a guaranteed queue slot
      grant_c   = (state_q == RUN)
                  && (32'(crd_out) < NUM_CRD)
                  && ((32'(crd_out) + 32'(occ_d)) < DEPTH);
      crd_d     = crd_out - CRD_W'(consume_c) + CRD_W'(grant_c);

      case (state_q)
         STOP:    if (link.RXLINKACTIVEREQ)  state_d = RUN;
         RUN:     if (!link.RXLINKACTIVEREQ) state_d = DEACT;
         DEACT:   if (crd_out == '0)         state_d = STOP;
         default:                            state_d = STOP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q              <= STOP;
         link.RXLINKACTIVEACK <= 1'b0;
         link.RXLCRDV         <= 1'b0;
         crd_out              <= '0;
         occ_q                <= '0;
         deq_valid            <= 1'b0;
         tgt_err              <= 1'b0;
         ovf_err              <= 1'b0;
      end else begin
         state_q              <= state_d;
         link.RXLINKACTIVEACK <= (state_d != STOP);
         link.RXLCRDV         <= grant_c;
         crd_out              <= crd_d;
         occ_q                <= occ_d;
         deq_valid            <= (occ_d != '0);
         tgt_err              <= tgt_bad_c;
         ovf_err              <= ovf_c;
      end
   end

   sfifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_c),
      .din   (link.RXFLIT),
      .pop   (pop_c),
      .dout  (deq_flit)
   );

endmodule

// File: tb/tb_chi_rx_link_chan.sv
// Self-checking bench for chi_rx_link_chan against a queue-based credit/link model.
module tb_chi_rx_link_chan;
   localparam int FW      = 65;
   localparam int DEPTH   = 4;
   localparam int NUM_CRD = 4;
   localparam int MY_ID   = 0;
   localparam int RET_OPC = 0;
   localparam int M_DOWN = 0, M_UP = 1, M_CLOSING = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          deq_ready;
   logic [FW-1:0] deq_flit;
   logic          deq_valid;
   logic [3:0]    crd_out;
   logic          tgt_err;
   logic          ovf_err;
   logic [8:0]    dut_vec;

   chi_rx_link_chan_if #(.FLIT_W(FW)) link ();

   chi_rx_link_chan #(
      .FLIT_W(FW), .DEPTH(DEPTH), .NUM_CRD(NUM_CRD), .OPC_LSB(0), .OPC_W(6),
      .TGT_LSB(58), .TGT_W(7), .LCRD_RET_OPC(RET_OPC), .MY_ID(MY_ID)
   ) dut (
      .clock(clock), .reset(reset), .link(link), .deq_flit(deq_flit),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .crd_out(crd_out),
      .tgt_err(tgt_err), .ovf_err(ovf_err)
   );

   always #5 clock = ~clock;

   assign dut_vec = {link.RXLINKACTIVEACK, link.RXLCRDV, crd_out, deq_valid, tgt_err, ovf_err};

   // Reference model state
   int            m_crd;
   logic [FW-1:0] m_q[$];
   int            m_mode;
   bit            m_ack, m_lcrdv, m_tgt, m_ovf;
   int            n_chk = 0;
   int            n_fail = 0;

   function automatic logic [8:0] exp_vec();
      return {m_ack, m_lcrdv, 4'(m_crd), (m_q.size() != 0), m_tgt, m_ovf};
   endfunction

   function automatic logic [FW-1:0] mk_flit(input int opc, input int tgt, input int tag);
      logic [FW-1:0] f;
      f = FW'({$urandom(), $urandom(), $urandom()});
      f[5:0]   = 6'(opc);
      f[64:58] = 7'(tgt);
      f[15:8]  = 8'(tag);
      return f;
   endfunction

   // Advance one clock, updating the model from the inputs currently driven
   task automatic tick();
      int crd0;
      bit grant;
      logic [FW-1:0] f;
      f = link.RXFLIT;
      crd0 = m_crd;
      if (reset) begin
         m_crd = 0; m_q.delete(); m_mode = M_DOWN;
         m_ack = 0; m_lcrdv = 0; m_tgt = 0; m_ovf = 0;
      end else begin
         m_ovf = link.RXFLITV && (crd0 == 0);
         m_tgt = 0;
         if (deq_ready && m_q.size() != 0) void'(m_q.pop_front());
         if (link.RXFLITV && crd0 != 0) begin
            m_crd--;
            if (f[5:0] != 6'(RET_OPC)) begin
               if (f[64:58] == 7'(MY_ID)) m_q.push_back(f);
               else m_tgt = 1;
            end
         end
         grant = (m_mode == M_UP) && (crd0 < NUM_CRD) && (crd0 + m_q.size() < DEPTH);
         m_lcrdv = grant;
         if (grant) m_crd++;
         case (m_mode)
            M_DOWN:  if (link.RXLINKACTIVEREQ) m_mode = M_UP;
            M_UP:    if (!link.RXLINKACTIVEREQ) m_mode = M_CLOSING;
            default: if (crd0 == 0) m_mode = M_DOWN;
         endcase
         m_ack = (m_mode != M_DOWN);
      end
      @(posedge clock);
      #1;
   endtask

   // Credit/occupancy invariant and no push into a full queue
   always @(negedge clock) begin
      if (!reset) begin
         n_chk++;
         if ((32'(crd_out) + 32'(dut.occ_q) > DEPTH) ||
             (dut.push_c && !dut.pop_c && 32'(dut.occ_q) == DEPTH)) begin
            n_fail++;
            $display("FAIL invariant: crd_out=%0d occ=%0d push=%0b, required crd_out+occ<=%0d and no full push",
                     crd_out, dut.occ_q, dut.push_c, DEPTH);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_chk++;
      if (dut_vec !== 9'd0) begin n_fail++; $display("FAIL reset_state: got %h exp %h", dut_vec, 9'd0); end
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_model: got %h exp %h", dut_vec, exp_vec()); end
      reset = 1'b0;
   endtask

   task automatic test_linkup();
      int first = -1, last = -1, cnt = 0;
      link.RXLINKACTIVEREQ = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL linkup_cyc%0d: got %h exp %h", c, dut_vec, exp_vec()); end
         if (c == 0) begin
            n_chk++;
            if (link.RXLINKACTIVEACK !== 1'b1) begin n_fail++; $display("FAIL linkup_ack: got %b exp 1", link.RXLINKACTIVEACK); end
         end
         if (link.RXLCRDV === 1'b1) begin
            cnt++; last = c;
            if (first < 0) first = c;
         end
      end
      n_chk++;
      if (cnt != 4 || last - first != 3) begin n_fail++; $display("FAIL linkup_lcrdv: got %0d grants span %0d exp 4 consecutive", cnt, last - first + 1); end
      n_chk++;
      if (crd_out !== 4'd4) begin n_fail++; $display("FAIL linkup_crd: got %0d exp 4", crd_out); end
   endtask

   task automatic test_fill();
      logic [FW-1:0] f[4];
      int cnt = 0;
      deq_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f[i] = mk_flit($urandom_range(1, 63), MY_ID, i);
         link.RXFLITV = 1'b1; link.RXFLIT = f[i];
         tick();
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fill_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
      end
      link.RXFLITV = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (link.RXLCRDV === 1'b1) cnt++;
      end
      n_chk++;
      if (cnt != 0 || crd_out !== 4'd0 || deq_valid !== 1'b1) begin
         n_fail++; $display("FAIL fill_full: got lcrdv=%0d crd=%0d valid=%b exp 0/0/1", cnt, crd_out, deq_valid);
      end
      n_chk++;
      if (deq_flit !== f[0]) begin n_fail++; $display("FAIL fill_head: got %h exp %h", deq_flit, f[0]); end
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      cnt = (link.RXLCRDV === 1'b1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (link.RXLCRDV === 1'b1) cnt++;
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL pop_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
      end
      n_chk++;
      if (cnt != 1) begin n_fail++; $display("FAIL pop_regrant: got %0d grants exp 1", cnt); end
      n_chk++;
      if (deq_flit !== f[1]) begin n_fail++; $display("FAIL pop_head: got %h exp %h", deq_flit, f[1]); end
   endtask

   task automatic test_tgt_err();
      logic [FW-1:0] head;
      int tcnt = 0, gcnt = 0;
      head = m_q[0];
      link.RXFLITV = 1'b1; link.RXFLIT = mk_flit($urandom_range(1, 63), MY_ID + 1, 99);
      tick();
      link.RXFLITV = 1'b0;
      n_chk++;
      if (crd_out !== 4'd0 || tgt_err !== 1'b1) begin n_fail++; $display("FAIL tgt_first: got crd=%0d tgt=%b exp 0/1", crd_out, tgt_err); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (tgt_err === 1'b1) tcnt++;
         if (link.RXLCRDV === 1'b1) gcnt++;
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL tgt_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
      end
      n_chk++;
      if (tcnt != 0 || gcnt != 1) begin n_fail++; $display("FAIL tgt_pulse: got extra_tgt=%0d grants=%0d exp 0/1", tcnt, gcnt); end
      n_chk++;
      if (deq_flit !== head) begin n_fail++; $display("FAIL tgt_queue: got %h exp %h", deq_flit, head); end
   endtask

   task automatic test_back_to_back();
      int exp_tag = 0;
      deq_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      for (int i = 0; i < 22; i++) begin
         if (deq_valid === 1'b1) begin
            n_chk++;
            if (32'(deq_flit[15:8]) != exp_tag) begin n_fail++; $display("FAIL b2b_order: got tag %0d exp %0d", deq_flit[15:8], exp_tag); end
            exp_tag++;
         end
         link.RXFLITV = (i < 16);
         link.RXFLIT  = mk_flit($urandom_range(1, 63), MY_ID, i);
         tick();
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL b2b_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
         if (i >= 2 && i < 16) begin
            n_chk++;
            if (link.RXLCRDV !== 1'b1 || crd_out !== 4'd2) begin
               n_fail++; $display("FAIL b2b_steady%0d: got lcrdv=%b crd=%0d exp 1/2", i, link.RXLCRDV, crd_out);
            end
         end
      end
      link.RXFLITV = 1'b0;
      n_chk++;
      if (exp_tag != 16) begin n_fail++; $display("FAIL b2b_count: got %0d pops exp 16", exp_tag); end
   endtask

   task automatic test_deact();
      logic [FW-1:0] kept;
      int t = 0, zt = -1, at = -1, gcnt = 0;
      deq_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      deq_ready = 1'b0;
      kept = mk_flit($urandom_range(1, 63), MY_ID, 200);
      link.RXFLITV = 1'b1; link.RXFLIT = kept;
      tick();
      link.RXFLITV = 1'b0;
      tick(); tick();
      n_chk++;
      if (crd_out !== 4'd3) begin n_fail++; $display("FAIL deact_pre: got crd %0d exp 3", crd_out); end
      link.RXLINKACTIVEREQ = 1'b0;
      for (int i = 0; i < 8; i++) begin
         link.RXFLITV = (i >= 1 && i <= 3);
         link.RXFLIT  = mk_flit(RET_OPC, $urandom_range(0, 127), 0);
         tick();
         t++;
         if (link.RXLCRDV === 1'b1) gcnt++;
         if (zt < 0 && crd_out === 4'd0) zt = t;
         if (at < 0 && link.RXLINKACTIVEACK === 1'b0) at = t;
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL deact_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
      end
      link.RXFLITV = 1'b0;
      n_chk++;
      if (gcnt != 0) begin n_fail++; $display("FAIL deact_lcrdv: got %0d grants exp 0", gcnt); end
      n_chk++;
      if (zt < 0 || at - zt != 1) begin n_fail++; $display("FAIL deact_ack: got ack fall at %0d crd zero at %0d exp 1 apart", at, zt); end
      n_chk++;
      if (deq_valid !== 1'b1 || deq_flit !== kept) begin n_fail++; $display("FAIL deact_queue: got %b/%h exp 1/%h", deq_valid, deq_flit, kept); end
   endtask

   task automatic test_ovf_reset();
      int ocnt = 0, gcnt = 0;
      link.RXFLITV = 1'b1; link.RXFLIT = mk_flit($urandom_range(1, 63), MY_ID, 7);
      tick();
      link.RXFLITV = 1'b0;
      n_chk++;
      if (ovf_err !== 1'b1 || tgt_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse: got ovf=%b tgt=%b exp 1/0", ovf_err, tgt_err); end
      for (int i = 0; i < 2; i++) begin
         tick();
         if (ovf_err === 1'b1) ocnt++;
         n_chk++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ovf_cyc%0d: got %h exp %h", i, dut_vec, exp_vec()); end
      end
      n_chk++;
      if (ocnt != 0 || crd_out !== 4'd0) begin n_fail++; $display("FAIL ovf_after: got extra=%0d crd=%0d exp 0/0", ocnt, crd_out); end
      link.RXLINKACTIVEREQ = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      link.RXFLITV = 1'b1; link.RXFLIT = mk_flit($urandom_range(1, 63), MY_ID, 8);
      tick();
      link.RXFLITV = 1'b0;
      tick();
      n_chk++;
      if (dut_vec !== exp_vec() || m_q.size() != 2) begin n_fail++; $display("FAIL pre_reset: got %h exp %h q=%0d", dut_vec, exp_vec(), m_q.size()); end
      reset = 1'b1; link.RXLINKACTIVEREQ = 1'b0;
      tick();
      reset = 1'b0;
      n_chk++;
      if ({link.RXLINKACTIVEACK, link.RXLCRDV, crd_out, deq_valid} !== 7'd0) begin
         n_fail++; $display("FAIL mid_reset: got ack=%b lcrdv=%b crd=%0d valid=%b exp all 0",
                            link.RXLINKACTIVEACK, link.RXLCRDV, crd_out, deq_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (link.RXLCRDV === 1'b1) gcnt++;
      end
      n_chk++;
      if (gcnt != 0 || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL post_reset: got grants=%0d vec %h exp 0/%h", gcnt, dut_vec, exp_vec()); end
   endtask

   initial begin
      reset = 1'b1;
      deq_ready = 1'b0;
      link.RXLINKACTIVEREQ = 1'b0;
      link.RXFLITPEND = 1'b0;
      link.RXFLITV = 1'b0;
      link.RXFLIT = '0;
      m_crd = 0; m_mode = M_DOWN;
      m_ack = 0; m_lcrdv = 0; m_tgt = 0; m_ovf = 0;
      test_reset();
      test_linkup();
      test_fill();
      test_tgt_err();
      test_back_to_back();
      test_deact();
      test_ovf_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
